// File: rtl/ui_mode_ctrl_pkg.sv
// Shared definitions for the front-panel command sequencer: mode encodings,
// button bit positions, default timing and counter-width helpers.
`default_nettype none

package ui_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_PROG_HORA  = 2'd1,
    MODE_PROG_FECHA = 2'd2,
    MODE_PROG_CRONO = 2'd3
  } mode_e;

  localparam int FIELD_W = 2;

  localparam int DEF_HOLD_MS    = 500;
  localparam int DEF_REPEAT_MS  = 100;
  localparam int DEF_TIMEOUT_MS = 10000;
  localparam int DEF_N_FIELDS   = 3;

  // Bit positions inside the packed button-level vector.
  localparam int B_AU  = 0;
  localparam int B_DIS = 1;
  localparam int B_L   = 2;
  localparam int B_R   = 3;
  localparam int B_F   = 4;
  localparam int B_PRH = 5;
  localparam int B_PRF = 6;
  localparam int B_PRC = 7;
  localparam int B_ICR = 8;
  localparam int N_BTN = 9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ui_mode_ctrl_repeat_pulse.sv
// Press/hold/auto-repeat pulse generator for one button: one pulse on the
// press edge, one after HOLD_MS ticks held, then one every REPEAT_MS ticks.
`default_nettype none

module ui_mode_ctrl_repeat_pulse
  import ui_mode_ctrl_pkg::*;
#(
  parameter int HOLD_MS   = DEF_HOLD_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic level_i,
  input  logic edge_i,
  input  logic enable_i,
  input  logic clear_i,
  input  logic inhibit_i,
  output logic pulse_o
);

  localparam int CW = cnt_width(max_int(HOLD_MS, REPEAT_MS));

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          limit_hit;

  // Once the first hold pulse fires, the same counter is reused for the repeat period.
  assign limit_hit = rep_q ? (cnt_q == CW'(REPEAT_MS - 1))
                           : (cnt_q == CW'(HOLD_MS - 1));

  always_comb begin
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pulse_o = 1'b0;
    if (clear_i || !enable_i || !level_i || inhibit_i) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (edge_i) begin
      pulse_o = 1'b1;
      cnt_d   = '0;
      rep_d   = 1'b0;
    end else if (tick_i) begin
      if (limit_hit) begin
        pulse_o = 1'b1;
        cnt_d   = '0;
        rep_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ui_mode_ctrl.sv
// Front-panel command sequencer: programming-mode FSM, field cursor, and
// registered single-cycle inc/dec/format/commit/abort pulses plus chrono run level.
`default_nettype none

module ui_mode_ctrl
  import ui_mode_ctrl_pkg::*;
#(
  parameter int HOLD_MS    = DEF_HOLD_MS,
  parameter int REPEAT_MS  = DEF_REPEAT_MS,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int N_FIELDS   = DEF_N_FIELDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_ms,
  input  logic               au,
  input  logic               dis,
  input  logic               l,
  input  logic               r,
  input  logic               f,
  input  logic               prh,
  input  logic               prf,
  input  logic               prc,
  input  logic               icr,
  output logic [1:0]         mode,
  output logic [FIELD_W-1:0] field,
  output logic               inc,
  output logic               dec,
  output logic               fmt_toggle,
  output logic               commit,
  output logic               abort,
  output logic               crono_run
);

  localparam int TOUT_W = cnt_width(max_int(max_int(HOLD_MS, REPEAT_MS), TIMEOUT_MS));
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(N_FIELDS - 1);

  logic [N_BTN-1:0]   lvl, prev_q, edge_v;
  mode_e              mode_q, mode_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic [TOUT_W-1:0]  tout_q, tout_d;
  logic               crono_q, crono_d;
  logic               inc_q, dec_q;
  logic               fmt_q, fmt_d;
  logic               commit_q, commit_d;
  logic               abort_q, abort_d;

  logic in_prog, own_edge, tout_hit, leave, activity, both_held;
  logic pulse_au, pulse_dis;

  assign lvl    = {icr, prc, prf, prh, f, r, l, dis, au};
  assign edge_v = lvl & ~prev_q;

  assign in_prog  = (mode_q != MODE_NORMAL);
  assign own_edge = ((mode_q == MODE_PROG_HORA)  && edge_v[B_PRH]) ||
                    ((mode_q == MODE_PROG_FECHA) && edge_v[B_PRF]) ||
                    ((mode_q == MODE_PROG_CRONO) && edge_v[B_PRC]);
  assign tout_hit = in_prog && tick_ms && (tout_q >= TOUT_W'(TIMEOUT_MS - 1));
  assign leave    = in_prog && (own_edge || tout_hit);
  assign both_held = au && dis;
  assign activity  = (|edge_v[B_F:B_AU]) || pulse_au || pulse_dis;

  ui_mode_ctrl_repeat_pulse #(
    .HOLD_MS   (HOLD_MS),
    .REPEAT_MS (REPEAT_MS)
  ) u_rep_au (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick_ms),
    .level_i   (au),
    .edge_i    (edge_v[B_AU]),
    .enable_i  (in_prog),
    .clear_i   (leave),
    .inhibit_i (both_held),
    .pulse_o   (pulse_au)
  );

  ui_mode_ctrl_repeat_pulse #(
    .HOLD_MS   (HOLD_MS),
    .REPEAT_MS (REPEAT_MS)
  ) u_rep_dis (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick_ms),
    .level_i   (dis),
    .edge_i    (edge_v[B_DIS]),
    .enable_i  (in_prog),
    .clear_i   (leave),
    .inhibit_i (both_held),
    .pulse_o   (pulse_dis)
  );

  always_comb begin
    mode_d   = mode_q;
    field_d  = field_q;
    tout_d   = tout_q;
    crono_d  = crono_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    // Format toggle follows the mode held at the edge, even on an entry/exit cycle.
    fmt_d    = edge_v[B_F] && ((mode_q == MODE_NORMAL) || (mode_q == MODE_PROG_HORA));

    if (!in_prog) begin
      field_d = '0;
      tout_d  = '0;
      if (edge_v[B_ICR]) crono_d = !crono_q;
      if (edge_v[B_PRH]) begin
        mode_d = MODE_PROG_HORA;
      end else if (edge_v[B_PRF]) begin
        mode_d = MODE_PROG_FECHA;
      end else if (edge_v[B_PRC]) begin
        mode_d  = MODE_PROG_CRONO;
        crono_d = 1'b0;
      end
    end else if (leave) begin
      mode_d   = MODE_NORMAL;
      field_d  = '0;
      tout_d   = '0;
      commit_d = own_edge;
      abort_d  = !own_edge;
    end else begin
      if (activity) begin
        tout_d = '0;
      end else if (tick_ms) begin
        tout_d = tout_q + 1'b1;
      end
      if (edge_v[B_R] && !edge_v[B_L]) begin
        field_d = (field_q == FIELD_LAST) ? '0 : field_q + 1'b1;
      end else if (edge_v[B_L] && !edge_v[B_R]) begin
        field_d = (field_q == '0) ? FIELD_LAST : field_q - 1'b1;
      end
    end
  end

  // Previous levels reset high so a button held through reset release gives no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= '1;
      mode_q   <= MODE_NORMAL;
      field_q  <= '0;
      tout_q   <= '0;
      crono_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      fmt_q    <= 1'b0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      prev_q   <= lvl;
      mode_q   <= mode_d;
      field_q  <= field_d;
      tout_q   <= tout_d;
      crono_q  <= crono_d;
      inc_q    <= pulse_au;
      dec_q    <= pulse_dis;
      fmt_q    <= fmt_d;
      commit_q <= commit_d;
      abort_q  <= abort_d;
    end
  end

  assign mode       = mode_q;
  assign field      = field_q;
  assign inc        = inc_q;
  assign dec        = dec_q;
  assign fmt_toggle = fmt_q;
  assign commit     = commit_q;
  assign abort      = abort_q;
  assign crono_run  = crono_q;

endmodule

`default_nettype wire
